// File: rtl/flit_arbiter.sv
// flit_arbiter: packet-granular round-robin arbiter sharing one flit sink
// between N_REQ sources. A grant is held from HEAD to TAIL so packets never
// interleave; a watchdog releases a lock whose owner stops presenting flits.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid[N_REQ]          per-requester flit valid
//   req_flit[N_REQ*FLIT_W]    requester i at [i*FLIT_W +: FLIT_W]
//   req_ready[N_REQ]          per-requester accept (combinational)
//   out_valid, out_flit       registered output flit toward the depacketizer
//   out_ready                 depacketizer accepts out_flit
//   grant_id                  current/last granted requester
//   busy                      packet lock held
//   timeout_err               one-cycle pulse on watchdog release
module flit_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned FLIT_W  = 48,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*FLIT_W-1:0]    req_flit,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       out_valid,
   output logic [FLIT_W-1:0]          out_flit,
   input  logic                       out_ready,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int unsigned ID_W = $clog2(N_REQ);
   localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic [0:0]        state, state_n;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_n, grant_n;
   logic [ID_W-1:0]   sel, idx, xfer_id;
   logic              sel_found, space, grant_ok, xfer, starved;
   logic [FLIT_W-1:0] xfer_flit, out_flit_n;
   logic [1:0]        xfer_type;
   logic              out_valid_n, timeout_err_n;
   logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
   logic [FLIT_W-1:0] req_flit_a [N_REQ];

   // Unpack the flat flit bus into one word per requester
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_flit_a[g] = req_flit[g*FLIT_W +: FLIT_W];
   end

   // First requester at or after rr_ptr presenting a HEAD or SINGLE
   always_comb begin
      sel       = rr_ptr;
      sel_found = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
         if (!sel_found && req_valid[idx] &&
             (req_flit_a[idx][FLIT_W-1 -: 2] == T_HEAD ||
              req_flit_a[idx][FLIT_W-1 -: 2] == T_SINGLE)) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   // Only one requester is ever offered ready: the lock owner, or the pick
   assign space     = !out_valid || out_ready;
   assign xfer_id   = (state == S_LOCKED) ? grant_id : sel;
   assign grant_ok  = (state == S_LOCKED) || sel_found;
   assign xfer      = grant_ok && space && req_valid[xfer_id];
   assign xfer_flit = req_flit_a[xfer_id];
   assign xfer_type = xfer_flit[FLIT_W-1 -: 2];
   assign starved   = !req_valid[grant_id];
   assign busy      = (state == S_LOCKED);

   always_comb begin
      req_ready          = '0;
      req_ready[xfer_id] = grant_ok && space;
   end

   // Next-state and output logic
   always_comb begin
      state_n       = state;
      rr_ptr_n      = rr_ptr;
      grant_n       = grant_id;
      out_valid_n   = out_valid;
      out_flit_n    = out_flit;
      timeout_err_n = 1'b0;
      wd_cnt_n      = wd_cnt;

      if (xfer) begin
         out_valid_n = 1'b1;
         out_flit_n  = xfer_flit;
      end else if (out_ready) begin
         out_valid_n = 1'b0;
      end

      case (state)
         S_IDLE: begin
            wd_cnt_n = '0;
            if (xfer) begin
               grant_n  = sel;
               rr_ptr_n = ID_W'((32'(sel) + 1) % N_REQ);
               if (xfer_type == T_HEAD) state_n = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (xfer) begin
               wd_cnt_n = '0;
               if (xfer_type == T_TAIL || xfer_type == T_SINGLE) state_n = S_IDLE;
            end else if (TIMEOUT != 0 && starved) begin
               // Release without synthesizing a tail; rr_ptr already moved at the head
               if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  state_n       = S_IDLE;
                  wd_cnt_n      = '0;
                  timeout_err_n = 1'b1;
               end else begin
                  wd_cnt_n = wd_cnt + WD_W'(1);
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         out_valid   <= 1'b0;
         out_flit    <= '0;
         timeout_err <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         state       <= state_n;
         rr_ptr      <= rr_ptr_n;
         grant_id    <= grant_n;
         out_valid   <= out_valid_n;
         out_flit    <= out_flit_n;
         timeout_err <= timeout_err_n;
         wd_cnt      <= wd_cnt_n;
      end
   end

   // Flit-type encodings kept for reference alongside the decode above
   logic unused_body;
   assign unused_body = (T_BODY == 2'b00);

endmodule

// File: tb/tb_flit_arbiter.sv
// tb_flit_arbiter: directed scenarios followed by randomized packet traffic,
// all checked every cycle against a requester-level reference model.
module tb_flit_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 48;
   localparam int unsigned TO = 4;

   localparam logic [1:0] BODY   = 2'b00;
   localparam logic [1:0] HEAD   = 2'b01;
   localparam logic [1:0] TAIL   = 2'b10;
   localparam logic [1:0] SINGLE = 2'b11;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_flit;
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic [W-1:0]     out_flit;
   logic             out_ready;
   logic [1:0]       grant_id;
   logic             busy;
   logic             timeout_err;

   logic [W-1:0]     fl [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_flit[g*W +: W] = fl[g];
   end

   flit_arbiter #(.N_REQ(N), .FLIT_W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner is -1 when no packet lock is held
   int           m_owner, m_rr, m_grant, m_starve;
   logic         m_ov, m_tout;
   logic [W-1:0] m_of;
   logic [N-1:0] last_xfer;

   function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [15:0] p);
      logic [29:0] mid;
      mid = 30'($urandom);
      return {t, mid, p};
   endfunction

   function automatic logic [1:0] ftype(input logic [W-1:0] f);
      return f[W-1 -: 2];
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_grant = 0; m_starve = 0;
      m_ov = 1'b0; m_tout = 1'b0; m_of = '0; last_xfer = '0;
   endtask

   // One clock cycle: inputs already applied at the preceding negedge
   task automatic step();
      logic [N-1:0] er;
      logic         space;
      int           pick, who, c;
      #1;
      chk("out_valid",   W'(out_valid),   W'(m_ov));
      chk("out_flit",    out_flit,        m_of);
      chk("busy",        W'(busy),        W'(m_owner >= 0));
      chk("grant_id",    W'(grant_id),    W'(m_grant));
      chk("timeout_err", W'(timeout_err), W'(m_tout));
      space = !m_ov || out_ready;
      er = '0;
      pick = -1;
      if (m_owner >= 0) pick = m_owner;
      else begin
         for (int k = 0; k < int'(N); k++) begin
            c = (m_rr + k) % int'(N);
            if (pick < 0 && req_valid[c] && (ftype(fl[c]) == HEAD || ftype(fl[c]) == SINGLE))
               pick = c;
         end
      end
      if (pick >= 0) er[pick] = space;
      chk("req_ready", W'(req_ready), W'(er));
      last_xfer = req_valid & er;
      who = -1;
      for (int i = 0; i < int'(N); i++) if (last_xfer[i]) who = i;
      m_tout = 1'b0;
      if (who >= 0) begin
         m_ov = 1'b1;
         m_of = fl[who];
         m_starve = 0;
         if (m_owner < 0) begin
            m_grant = who;
            m_rr = (who + 1) % int'(N);
            if (ftype(fl[who]) == HEAD) m_owner = who;
         end else if (ftype(fl[who]) == TAIL || ftype(fl[who]) == SINGLE) begin
            m_owner = -1;
         end
      end else begin
         if (out_ready) m_ov = 1'b0;
         if (m_owner >= 0 && !req_valid[m_owner]) begin
            m_starve++;
            if (m_starve == int'(TO)) begin
               m_owner = -1; m_starve = 0; m_tout = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   // Present a flit and cycle until it is taken (bounded)
   task automatic send(input int i, input logic [1:0] t, input logic [15:0] p);
      req_valid[i] = 1'b1;
      fl[i] = mk(t, p);
      for (int n = 0; n < 40; n++) begin
         step();
         if (last_xfer[i]) break;
      end
      chk("send_accept", W'(last_xfer[i]), W'(1));
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < int'(N); i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int   exp_rr [6];
      logic pend [N];
      logic inpkt [N];
      int   rem [N], sil [N], wait_c [N];

      exp_rr = '{0, 1, 2, 3, 0, 1};
      reset_n = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      for (int i = 0; i < int'(N); i++) fl[i] = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;

      // Single packet from req0
      send(0, HEAD, 16'h1111);
      send(0, BODY, 16'h2222);
      send(0, BODY, 16'h3333);
      send(0, TAIL, 16'h4444);
      req_valid[0] = 1'b0;
      chk("t1_tail_payload", W'(out_flit[15:0]), W'(16'h4444));
      chk("t1_busy_after_tail", W'(busy), W'(0));
      step();

      // Round-robin among continuous SINGLE sources, from a fresh reset
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         req_valid[i] = 1'b1;
         fl[i] = mk(SINGLE, 16'(16'h5000 + i));
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_grant", W'(onehot_idx(last_xfer)), W'(exp_rr[k]));
      end
      req_valid = '0;

      // No interleave: req2 HEAD waits for req1 TAIL
      send(1, HEAD, 16'h1a01);
      req_valid[2] = 1'b1;
      fl[2] = mk(HEAD, 16'h2a01);
      send(1, BODY, 16'h1a02);
      chk("t3_r2_blocked", W'(req_ready[2]), W'(0));
      send(1, TAIL, 16'h1a03);
      req_valid[1] = 1'b0;
      send(2, HEAD, 16'h2a01);
      chk("t3_r2_head_out", out_flit, fl[2]);
      send(2, TAIL, 16'h2a02);
      req_valid[2] = 1'b0;

      // Back-pressure mid-packet, valid held so no watchdog
      send(0, HEAD, 16'h00a0);
      send(0, BODY, 16'h00aa);
      out_ready = 1'b0;
      fl[0] = mk(BODY, 16'h00bb);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t4_ready_held", W'(req_ready[0]), W'(0));
         chk("t4_flit_held", W'(out_flit[15:0]), W'(16'h00aa));
      end
      out_ready = 1'b1;
      send(0, BODY, 16'h00bb);
      chk("t4_body_out", W'(out_flit[15:0]), W'(16'h00bb));
      send(0, TAIL, 16'h00cc);
      req_valid[0] = 1'b0;

      // Watchdog: req3 HEAD then silence
      send(3, HEAD, 16'h3b01);
      req_valid[3] = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("t5_no_early_tout", W'(timeout_err), W'(0));
      chk("t5_still_busy", W'(busy), W'(1));
      step();
      chk("t5_tout_pulse", W'(timeout_err), W'(1));
      chk("t5_busy_clear", W'(busy), W'(0));
      send(0, HEAD, 16'h0b01);
      chk("t5_tout_one_cycle", W'(timeout_err), W'(0));
      chk("t5_r0_granted", W'(grant_id), W'(0));
      send(0, TAIL, 16'h0b02);
      req_valid[0] = 1'b0;

      // Reset mid-packet drops the partial packet
      send(1, HEAD, 16'h1c01);
      send(1, BODY, 16'h1c02);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_out_valid", W'(out_valid), W'(0));
      chk("t6_rst_busy", W'(busy), W'(0));
      chk("t6_rst_grant", W'(grant_id), W'(0));
      model_reset();
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      req_valid[3] = 1'b1;
      fl[3] = mk(HEAD, 16'h3c01);
      send(2, HEAD, 16'h2c01);
      chk("t6_r2_first", W'(grant_id), W'(2));
      send(2, TAIL, 16'h2c02);
      req_valid[2] = 1'b0;
      send(3, HEAD, 16'h3c01);
      send(3, TAIL, 16'h3c02);
      req_valid = '0;
      step();

      // Randomized packet traffic with gaps, silences and back-pressure
      for (int i = 0; i < int'(N); i++) begin
         pend[i] = 1'b0; inpkt[i] = 1'b0; rem[i] = 0; sil[i] = 0; wait_c[i] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < int'(N); i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               if (inpkt[i]) fl[i] = mk((rem[i] > 0) ? BODY : TAIL, 16'($urandom));
               else if ($urandom_range(0, 3) == 0) fl[i] = mk(SINGLE, 16'($urandom));
               else begin
                  fl[i] = mk(HEAD, 16'($urandom));
                  rem[i] = int'($urandom_range(0, 3));
               end
               pend[i] = 1'b1;
               wait_c[i] = 0;
            end
            if (pend[i] && sil[i] == 0 && $urandom_range(0, 49) == 0)
               sil[i] = int'($urandom_range(1, 7));
            if (sil[i] > 0) begin
               req_valid[i] = 1'b0;
               sil[i]--;
            end else begin
               req_valid[i] = pend[i];
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         for (int i = 0; i < int'(N); i++) begin
            if (last_xfer[i]) begin
               case (ftype(fl[i]))
                  HEAD:    inpkt[i] = 1'b1;
                  BODY:    rem[i]--;
                  default: inpkt[i] = 1'b0;
               endcase
               pend[i] = 1'b0;
            end else if (pend[i]) begin
               wait_c[i]++;
               // A source whose lock was revoked abandons its stranded packet
               if (wait_c[i] > 30 && (ftype(fl[i]) == BODY || ftype(fl[i]) == TAIL)) begin
                  pend[i] = 1'b0;
                  inpkt[i] = 1'b0;
               end
            end
         end
      end
      req_valid = '0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/flit_arbiter.md
Name: flit_arbiter

Overview:
- Shares the single depacketizer flit input between N_REQ packetizer sources.
- Round-robin arbitration at packet granularity: a grant is held from head flit to tail flit, so flits of different packets never interleave.
- Registered 48-bit flit output with valid/ready handshake toward the depacketizer.
- Watchdog releases a stalled lock.

Parameters:
N_REQ, 4, number of requesters (2..8)
FLIT_W, 48, flit width; bits [47:46] = flit type, [15:0] = payload
TIMEOUT, 255, max consecutive starved cycles while locked before forced release; 0 disables

Ports:
clk  input  1  clock
reset_n  input  1  reset
req_valid  input  N_REQ  per-requester flit valid
req_flit  input  N_REQ*FLIT_W  per-requester flit; requester i at [i*FLIT_W +: FLIT_W]
req_ready  output  N_REQ  per-requester accept (combinational)
out_valid  output  1  output flit valid (registered)
out_flit  output  FLIT_W  output flit to depacketizer (registered)
out_ready  input  1  depacketizer accepts out_flit
grant_id  output  $clog2(N_REQ)  current/last granted requester
busy  output  1  high while a packet lock is held
timeout_err  output  1  one-cycle pulse on watchdog release

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_flit=0, grant_id=0, busy=0, timeout_err=0, rr pointer=0, state=IDLE, watchdog=0.
- Reset asserted mid-packet clears all state immediately. The partial packet is dropped, with no tail emitted.
- Flit type [47:46]:
  - 01 = HEAD
  - 00 = BODY
  - 10 = TAIL
  - 11 = SINGLE (head+tail)
- Output space: space = !out_valid || out_ready.
- Transfer: a flit transfers from requester i when req_valid[i] && req_ready[i].
  - Transferred flit is loaded into out_flit with out_valid=1 on the next edge (latency 1 cycle).
  - out_valid clears when out_ready=1 and no new flit is loaded.
  - Full throughput: one flit per cycle when out_ready is held high.
- State IDLE:
  - Eligible requesters: req_valid[i]=1 and type HEAD or SINGLE.
  - Selection: the first eligible i searching from rr pointer upward, wrapping modulo N_REQ.
  - req_ready[sel] = space; all other req_ready = 0.
  - BODY/TAIL flits from an unlocked requester are never accepted; they stall and are not an error.
  - On HEAD transfer: state goes to LOCKED, grant_id=sel, busy=1, rr pointer=(sel+1) mod N_REQ.
  - On SINGLE transfer: state stays IDLE, grant_id=sel, rr pointer=(sel+1) mod N_REQ, busy stays 0.
- State LOCKED:
  - req_ready[grant_id] = space; all others 0.
  - Any flit type is forwarded unchanged. A HEAD received while locked is forwarded as data and does not restart the lock.
  - Transfer of TAIL or SINGLE: state goes to IDLE and busy=0 on the same edge.
  - Next arbitration can occur in the following cycle, giving zero-bubble back-to-back packets.
- Watchdog:
  - Active only in LOCKED with TIMEOUT>0.
  - Counts cycles with req_valid[grant_id]=0; cleared by any transfer or on leaving LOCKED.
  - Output back-pressure (valid=1 with space=0) does not count.
  - When count reaches TIMEOUT: state goes to IDLE, busy=0, and timeout_err=1 for exactly one cycle.
  - No flit is synthesized. rr pointer is unchanged, since it was already advanced at the head.
- Simultaneous events:
  - Tail transfer and watchdog expiry on the same edge: the tail wins and timeout_err stays 0.
  - A single requester issuing tail then head on consecutive cycles wins again only if no other requester is eligible (fairness).

Test Plan:
- Single packet: req0 sends HEAD, 2×BODY, TAIL (payloads 0x1111, 0x2222, 0x3333, 0x4444), out_ready=1 -> out_flit sequence identical, each one cycle after its transfer; busy=1 from the HEAD edge to the TAIL edge; grant_id=0.
- Round-robin fairness: req0..req3 all hold SINGLE flits continuously, out_ready=1 -> grants in order 0,1,2,3,0,1, one per cycle.
- No interleave: req1 mid-packet while req2 presents HEAD -> req_ready[2]=0 until req1 TAIL transfers; req2 HEAD appears at out_flit on the cycle right after req1 TAIL.
- Back-pressure: out_ready=0 for 5 cycles mid-packet -> out_flit held stable, req_ready[grant]=0 while out_valid=1, no flit lost or duplicated; no timeout with TIMEOUT=4.
- Watchdog: TIMEOUT=4, req3 sends HEAD then drops req_valid -> timeout_err pulses one cycle, 4 cycles after the HEAD transfer; busy=0; req0 HEAD is accepted the next cycle.
- Reset mid-packet: reset_n low during a BODY flit -> out_valid, busy and grant_id go to 0 immediately; after release, a fresh packet from req2 is accepted normally from IDLE with rr pointer=0.
